// File: rtl/aes_ct_serializer_if.sv
// Output word stream of the ciphertext serializer: valid/ready handshake with a last-word marker.
interface aes_ct_serializer_if #(
  parameter int word_width_p = 32
) ();
  logic                    v;
  logic [word_width_p-1:0] data;
  logic                    last;
  logic                    ready;

  modport master (output v, output data, output last, input ready);
  modport slave  (input v, input data, input last, output ready);
endinterface

// File: rtl/aes_ct_serializer.sv
// Buffers ciphertext blocks from a non-stallable AES pipeline in a small FIFO and
// streams each block out MS-word first; publishes free slots for credit-based throttling.
module aes_ct_serializer #(
  parameter int block_width_p = 128,
  parameter int word_width_p  = 32,
  parameter int fifo_els_p    = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               v_i,
  input  logic [block_width_p-1:0]           ciphertext_i,
  output logic [$clog2(fifo_els_p+1)-1:0]    free_o,
  output logic                               overflow_o,
  aes_ct_serializer_if.master                stream_o
);

  localparam int words_lp  = block_width_p / word_width_p;
  localparam int cnt_w_lp  = $clog2(fifo_els_p + 1);
  localparam int ptr_w_lp  = $clog2(fifo_els_p);
  localparam int wcnt_w_lp = (words_lp > 1) ? $clog2(words_lp) : 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e                    state_q, state_d;
  logic [block_width_p-1:0]  mem_q [fifo_els_p];
  logic [block_width_p-1:0]  mem_d [fifo_els_p];
  logic [ptr_w_lp-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0]       rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]       count_q, count_d;
  logic [cnt_w_lp-1:0]       free_q, free_d;
  logic [wcnt_w_lp-1:0]      wcnt_q, wcnt_d;
  logic                      overflow_q, overflow_d;

  logic                      full, hs, pop, wr_en;
  logic [block_width_p-1:0]  head_shift;

  // A pop in the same cycle frees a slot, so a full FIFO can still take the incoming block.
  always_comb begin
    full  = (count_q == cnt_w_lp'(fifo_els_p));
    hs    = (state_q == SEND) && stream_o.ready;
    pop   = hs && (wcnt_q == wcnt_w_lp'(words_lp - 1));
    wr_en = v_i && (!full || pop);

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wcnt_d     = wcnt_q;
    overflow_d = overflow_q;
    state_d    = state_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = ciphertext_i;
      wr_ptr_d        = wr_ptr_q + ptr_w_lp'(1);
    end
    if (v_i && full && !pop) begin
      overflow_d = 1'b1;
    end
    if (hs) begin
      wcnt_d = pop ? '0 : wcnt_q + wcnt_w_lp'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
    end

    case ({wr_en, pop})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
    free_d = cnt_w_lp'(fifo_els_p) - count_d;

    // Looking at count_d lets a freshly written block be presented right after its write edge.
    case (state_q)
      IDLE:    if (count_d != '0) state_d = SEND;
      SEND:    if (count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      free_q     <= cnt_w_lp'(fifo_els_p);
      wcnt_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      free_q     <= free_d;
      wcnt_q     <= wcnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Word 0 is the most significant slice of the block.
  always_comb begin
    head_shift    = mem_q[rd_ptr_q] >> (word_width_p * (words_lp - 1 - int'(wcnt_q)));
    stream_o.v    = (state_q == SEND);
    stream_o.data = (state_q == SEND) ? head_shift[word_width_p-1:0] : '0;
    stream_o.last = (state_q == SEND) && (wcnt_q == wcnt_w_lp'(words_lp - 1));
  end

  assign free_o     = free_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Self-checking bench for aes_ct_serializer: fixed vectors, directed corner cases
// and random traffic compared against a block-queue reference model.
module tb_aes_ct_serializer;

  logic         clk;
  logic         rst_n;
  logic         v_in;
  logic [127:0] ct_in;
  logic [2:0]   free_out;
  logic         ovf_out;

  aes_ct_serializer_if #(.word_width_p(32)) stream_if ();

  aes_ct_serializer #(
    .block_width_p(128),
    .word_width_p (32),
    .fifo_els_p   (4)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .v_i         (v_in),
    .ciphertext_i(ct_in),
    .free_o      (free_out),
    .overflow_o  (ovf_out),
    .stream_o    (stream_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: queue of whole blocks, index of the word on offer, sticky overflow.
  logic [127:0] model_q[$];
  int           model_w;
  bit           model_ovf;

  typedef struct {
    logic         v;
    logic [127:0] ct;
    logic         rdy;
    logic         exp_v;
    logic [31:0]  exp_data;
    logic         exp_last;
    logic [2:0]   exp_free;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] modelWord();
    logic [127:0] blk;
    blk = model_q[0] >> (32 * (3 - model_w));
    return blk[31:0];
  endfunction

  task automatic checkModel(input string tag);
    logic exp_v;
    exp_v = (model_q.size() > 0);
    checkOutput({tag, ".v"}, 128'(stream_if.v), 128'(exp_v));
    checkOutput({tag, ".free"}, 128'(free_out), 128'(4 - model_q.size()));
    checkOutput({tag, ".ovf"}, 128'(ovf_out), 128'(model_ovf));
    if (exp_v) begin
      checkOutput({tag, ".data"}, 128'(stream_if.data), 128'(modelWord()));
      checkOutput({tag, ".last"}, 128'(stream_if.last), 128'(model_w == 3));
    end
  endtask

  // Drive one cycle of inputs, advance the model by the same edge, then compare.
  task automatic applyStimulus(input logic v, input logic [127:0] ct, input logic rdy, input string tag);
    bit hs, pop, acc;
    v_in            = v;
    ct_in           = v ? ct : 'x;
    stream_if.ready = rdy;
    hs  = (model_q.size() > 0) && rdy;
    pop = hs && (model_w == 3);
    acc = v && ((model_q.size() < 4) || pop);
    if (v && !acc) model_ovf = 1'b1;
    if (hs) begin
      if (pop) begin
        void'(model_q.pop_front());
        model_w = 0;
      end else begin
        model_w++;
      end
    end
    if (acc) model_q.push_back(ct);
    @(posedge clk);
    #1;
    checkModel(tag);
  endtask

  task automatic doReset(input string tag);
    v_in            = 1'b0;
    ct_in           = 'x;
    stream_if.ready = 1'b0;
    @(posedge clk);
    #($urandom_range(2, 7));
    rst_n = 1'b0;
    #1;
    model_q.delete();
    model_w   = 0;
    model_ovf = 1'b0;
    checkOutput({tag, ".rst_v"}, 128'(stream_if.v), 128'(1'b0));
    checkOutput({tag, ".rst_free"}, 128'(free_out), 128'(3'd4));
    checkOutput({tag, ".rst_ovf"}, 128'(ovf_out), 128'(1'b0));
    checkOutput({tag, ".rst_data"}, 128'(stream_if.data), 128'(32'h0));
    checkOutput({tag, ".rst_last"}, 128'(stream_if.last), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] blockOf(input int n);
    return {8'(n), 24'h0a0a0a, 8'(n), 24'h1b1b1b, 8'(n), 24'h2c2c2c, 8'(n), 24'h3d3d3d};
  endfunction

  initial begin
    logic [127:0] ct;
    rst_n           = 1'b1;
    v_in            = 1'b0;
    ct_in           = '0;
    stream_if.ready = 1'b0;
    model_w         = 0;
    model_ovf       = 1'b0;
    #2;

    doReset("reset");

    // Single block with the consumer always ready.
    ct = 128'h00112233_44556677_8899aabb_ccddeeff;
    vecs[0] = '{1'b1, ct,   1'b1, 1'b1, 32'h00112233, 1'b0, 3'd3};
    vecs[1] = '{1'b0, '0,   1'b1, 1'b1, 32'h44556677, 1'b0, 3'd3};
    vecs[2] = '{1'b0, '0,   1'b1, 1'b1, 32'h8899aabb, 1'b0, 3'd3};
    vecs[3] = '{1'b0, '0,   1'b1, 1'b1, 32'hccddeeff, 1'b1, 3'd3};
    vecs[4] = '{1'b0, '0,   1'b1, 1'b0, 32'h0,        1'b0, 3'd4};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].v, vecs[i].ct, vecs[i].rdy, $sformatf("single%0d", i));
      checkOutput($sformatf("vec%0d.v", i), 128'(stream_if.v), 128'(vecs[i].exp_v));
      checkOutput($sformatf("vec%0d.free", i), 128'(free_out), 128'(vecs[i].exp_free));
      if (vecs[i].exp_v) begin
        checkOutput($sformatf("vec%0d.data", i), 128'(stream_if.data), 128'(vecs[i].exp_data));
        checkOutput($sformatf("vec%0d.last", i), 128'(stream_if.last), 128'(vecs[i].exp_last));
      end
    end

    // Backpressure: ready toggles, one block takes eight cycles to drain.
    applyStimulus(1'b1, blockOf(7), 1'b0, "bp_wr");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, '0, logic'(i % 2), $sformatf("bp%0d", i));
    end
    checkOutput("bp_drained", 128'(stream_if.v), 128'(1'b0));

    // Fill four blocks, drop a fifth, then drain 16 words back to back.
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, blockOf(i), 1'b0, $sformatf("fill%0d", i));
    checkOutput("fill_free", 128'(free_out), 128'(3'd0));
    applyStimulus(1'b1, blockOf(5), 1'b0, "drop");
    checkOutput("drop_ovf", 128'(ovf_out), 128'(1'b1));
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("drain_word%0d", i), 128'(stream_if.data),
                  128'(32'(blockOf(i / 4 + 1) >> (32 * (3 - i % 4)))));
      applyStimulus(1'b0, '0, 1'b1, $sformatf("drain%0d", i));
    end
    checkOutput("drain_empty", 128'(stream_if.v), 128'(1'b0));

    // Full FIFO: write coincides with the last-word handshake and must be accepted.
    doReset("full_pop");
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, blockOf(i + 8), 1'b0, $sformatf("fp_fill%0d", i));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, $sformatf("fp_word%0d", i));
    checkOutput("fp_last_shown", 128'(stream_if.last), 128'(1'b1));
    applyStimulus(1'b1, blockOf(13), 1'b1, "fp_both");
    checkOutput("fp_ovf", 128'(ovf_out), 128'(1'b0));
    checkOutput("fp_free", 128'(free_out), 128'(3'd0));
    checkOutput("fp_next_head", 128'(stream_if.data), 128'(32'h0a0a0a0a));

    // Reset after word1 is accepted; the next block starts cleanly at word0.
    doReset("mid_pre");
    applyStimulus(1'b1, ct, 1'b0, "mid_wr");
    applyStimulus(1'b0, '0, 1'b1, "mid_w0");
    applyStimulus(1'b0, '0, 1'b1, "mid_w1");
    doReset("mid");
    applyStimulus(1'b1, blockOf(20), 1'b0, "mid_new");
    checkOutput("mid_new_word0", 128'(stream_if.data), 128'(32'h140a0a0a));
    checkOutput("mid_new_last", 128'(stream_if.last), 128'(1'b0));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(logic'($urandom_range(0, 2) == 0),
                    {$urandom, $urandom, $urandom, $urandom},
                    logic'($urandom_range(0, 3) != 0),
                    $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
